// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit path.
//   - ASCII constants used by the instruction echo sequencer.
//   - Character FSM state encoding for the 8N1 byte engine.
//   - OVERSAMPLE: baud_tick pulses per serial bit.
//   - digit_char(): maps one instruction bit to ASCII '0' or '1'.
package uart_pkg;

    localparam logic [7:0] CHAR_ZERO = 8'h30;
    localparam logic [7:0] CHAR_CR   = 8'h0D;
    localparam logic [7:0] CHAR_LF   = 8'h0A;

    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

    function automatic logic [7:0] digit_char(input logic b);
        return CHAR_ZERO | {7'b0, b};
    endfunction

endpackage

// File: rtl/tx_byte_serializer.sv
// tx_byte_serializer: 8N1 byte engine, LSB first, idle-high line.
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   baud_tick    - 16x oversample pulse from the shared divider
//   load_i       - take din_i as the next byte (from idle, or on the final stop tick)
//   din_i        - byte to send
//   tx_o         - registered serial output
//   ready_o      - engine idle, a load starts a new frame
//   byte_end_o   - combinational: this cycle is the final tick of a stop bit
// Loading on the final stop tick chains the next start bit with no idle gap.
module tx_byte_serializer
    import uart_pkg::*;
#(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_tick,
    input  logic       load_i,
    input  logic [7:0] din_i,
    output logic       tx_o,
    output logic       ready_o,
    output logic       byte_end_o
);

    localparam logic [3:0] TickLast = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] StopLast = 4'(SB_TICK - 1);
    localparam logic [2:0] BitLast  = 3'(DBIT - 1);

    tx_state_e  state_q;
    logic [3:0] tick_q;
    logic [2:0] bit_q;
    logic [7:0] shift_q;
    logic       tx_q;

    assign tx_o       = tx_q;
    assign ready_o    = (state_q == StIdle);
    assign byte_end_o = (state_q == StStop) && baud_tick && (tick_q == StopLast);

    // tx_q is assigned alongside every state change so the line level always
    // matches the state it has just entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load_i) begin
                        state_q <= StStart;
                        shift_q <= din_i;
                        tick_q  <= '0;
                        tx_q    <= 1'b0;
                    end
                end
                StStart: begin
                    if (baud_tick) begin
                        if (tick_q == TickLast) begin
                            state_q <= StData;
                            tick_q  <= '0;
                            bit_q   <= '0;
                            tx_q    <= shift_q[0];
                        end else begin
                            tick_q <= tick_q + 4'd1;
                        end
                    end
                end
                StData: begin
                    if (baud_tick) begin
                        if (tick_q == TickLast) begin
                            tick_q  <= '0;
                            shift_q <= {1'b0, shift_q[7:1]};
                            if (bit_q == BitLast) begin
                                state_q <= StStop;
                                tx_q    <= 1'b1;
                            end else begin
                                bit_q <= bit_q + 3'd1;
                                tx_q  <= shift_q[1];
                            end
                        end else begin
                            tick_q <= tick_q + 4'd1;
                        end
                    end
                end
                StStop: begin
                    if (baud_tick) begin
                        if (tick_q == StopLast) begin
                            tick_q <= '0;
                            if (load_i) begin
                                state_q <= StStart;
                                shift_q <= din_i;
                                tx_q    <= 1'b0;
                            end else begin
                                state_q <= StIdle;
                            end
                        end else begin
                            tick_q <= tick_q + 4'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/instr_echo_tx.sv
// instr_echo_tx: echoes an IW-bit instruction over UART as ASCII '0'/'1'
// characters (MSB first) followed by CR LF.
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   baud_tick    - 16x oversample pulse from the shared divider
//   start        - single-cycle request, accepted only while busy is low
//   instruction  - value to echo, latched on acceptance
//   tx           - serial line (8N1, LSB first, idle high)
//   busy         - high from acceptance until the final stop bit completes
//   done_tick    - one-cycle pulse as the final stop bit completes
module instr_echo_tx
    import uart_pkg::*;
#(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16,
    parameter int unsigned IW      = 13
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          baud_tick,
    input  logic          start,
    input  logic [IW-1:0] instruction,
    output logic          tx,
    output logic          busy,
    output logic          done_tick
);

    localparam int unsigned           NChar   = IW + 2;
    localparam int unsigned           IdxW    = $clog2(NChar);
    localparam logic [IdxW-1:0]       LastIdx = IdxW'(NChar - 1);

    logic [IW-1:0]   latch_q;
    logic [IdxW-1:0] idx_q;
    logic            busy_q;
    logic            done_q;

    logic            ser_ready;
    logic            byte_end;
    logic            accept;
    logic            more;
    logic            load;
    logic [IdxW-1:0] next_idx;
    logic [7:0]      din;

    // Character k of the message built from word.
    function automatic logic [7:0] char_sel(input logic [IW-1:0] word, input int unsigned k);
        logic [IW-1:0] sh;
        sh = word >> (IW - 1 - k);
        if (k < IW)       return digit_char(sh[0]);
        else if (k == IW) return CHAR_CR;
        else              return CHAR_LF;
    endfunction

    assign accept   = start && !busy_q && ser_ready;
    assign more     = (idx_q != LastIdx);
    assign load     = accept || (busy_q && byte_end && more);
    assign next_idx = idx_q + IdxW'(1);

    // The latch is not yet valid in the accept cycle, so character 0 comes
    // straight from the input port.
    assign din = accept ? char_sel(instruction, 0) : char_sel(latch_q, 32'(next_idx));

    always_ff @(posedge clk) begin
        if (reset) begin
            latch_q <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                latch_q <= instruction;
                idx_q   <= '0;
                busy_q  <= 1'b1;
            end else if (busy_q && byte_end) begin
                if (more) begin
                    idx_q <= next_idx;
                end else begin
                    idx_q  <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy      = busy_q;
    assign done_tick = done_q;

    tx_byte_serializer #(
        .DBIT    (DBIT),
        .SB_TICK (SB_TICK)
    ) u_ser (
        .clk        (clk),
        .reset      (reset),
        .baud_tick  (baud_tick),
        .load_i     (load),
        .din_i      (din),
        .tx_o       (tx),
        .ready_o    (ser_ready),
        .byte_end_o (byte_end)
    );

endmodule

// File: tb/tb_instr_echo_tx.sv
module tb_instr_echo_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        baud_tick;
    logic        start = 1'b0;
    logic [12:0] instruction = '0;
    logic        tx;
    logic        busy;
    logic        done_tick;

    instr_echo_tx #(
        .DBIT    (8),
        .SB_TICK (16),
        .IW      (13)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_tick   (baud_tick),
        .start       (start),
        .instruction (instruction),
        .tx          (tx),
        .busy        (busy),
        .done_tick   (done_tick)
    );

    always #5 clk = ~clk;

    // Baud source: every cycle, or one pulse per 327 clocks in slow mode.
    bit          slow = 1'b0;
    int unsigned phase = 0;
    always @(posedge clk) phase <= (phase == 326) ? 0 : phase + 1;
    assign baud_tick = slow ? (phase == 326) : 1'b1;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];
    longint acc_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: UART receiver driven by baud_tick, pops the scoreboard per byte.
    bit         rx_act = 1'b0;
    int         rx_t = 0;
    logic [7:0] rx_sh = '0;
    always @(negedge clk) begin
        if (reset) begin
            rx_act = 1'b0;
        end else begin
            if (done_tick) begin
                done_cnt++;
                chk("busy_low_at_done", {63'b0, busy}, 64'd0);
            end
            if (!rx_act && tx === 1'b0) begin
                rx_act = 1'b1;
                rx_t = 0;
            end
            if (rx_act && baud_tick) begin
                rx_t++;
                if (rx_t % 16 == 8) begin
                    if (rx_t / 16 == 0) begin
                        chk("start_bit", {63'b0, tx}, 64'd0);
                    end else if (rx_t / 16 <= 8) begin
                        rx_sh[rx_t/16-1] = tx;
                    end else begin
                        chk("stop_bit", {63'b0, tx}, 64'd1);
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL rx_unexpected: actual=%0h required=none", rx_sh);
                        end else begin
                            chk("rx_byte", {56'b0, rx_sh}, {56'b0, exp_q.pop_front()});
                        end
                        rx_act = 1'b0;
                    end
                end
            end
        end
    end

    task automatic push_msg(input logic [12:0] ins);
        for (int k = 12; k >= 0; k--) exp_q.push_back(ins[k] ? 8'h31 : 8'h30);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Drive start for one cycle; check latency on the accepting edge.
    task automatic pulse_start(input logic [12:0] ins);
        @(negedge clk);
        instruction = ins;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        acc_cyc = cyc;
        chk("tx_low_after_accept", {63'b0, tx}, 64'd0);
        chk("busy_after_accept", {63'b0, busy}, 64'd1);
    endtask

    task automatic wait_done(input int budget, output longint at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_tick) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: actual=none required=done_tick");
        end
    endtask

    logic [7:0] t1_bytes [15] = '{8'h31, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30,
                                  8'h30, 8'h30, 8'h31, 8'h30, 8'h31, 8'h0D, 8'h0A};
    logic       slow_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        longint t;
        bit ok;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_tx", {63'b0, tx}, 64'd1);
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_done", {63'b0, done_tick}, 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Basic message and frame length
        done_cnt = 0;
        foreach (t1_bytes[i]) exp_q.push_back(t1_bytes[i]);
        pulse_start(13'b1000000000101);
        wait_done(3000, t);
        chk("t1_frame_len", 64'(t - acc_cyc), 64'd2400);
        repeat (20) @(negedge clk);
        chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("t1_done_count", 64'(done_cnt), 64'd1);

        // Re-pulsed start and changed instruction mid-frame
        done_cnt = 0;
        foreach (t1_bytes[i]) exp_q.push_back(t1_bytes[i]);
        pulse_start(13'b1000000000101);
        repeat (50) @(negedge clk);
        instruction = 13'h1FFF;
        for (int k = 0; k < 4; k++) begin
            repeat (300) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(3000, t);
        chk("t3_frame_len", 64'(t - acc_cyc), 64'd2400);
        repeat (50) @(negedge clk);
        chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("t3_done_count", 64'(done_cnt), 64'd1);

        // Reset during DATA of character 5, start held with reset
        done_cnt = 0;
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h31);
        pulse_start(13'b0101101001111);
        repeat (5 * 160 + 16 + 40) @(negedge clk);
        chk("t4_busy_before_reset", {63'b0, busy}, 64'd1);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_tx_after_reset", {63'b0, tx}, 64'd1);
        chk("t4_busy_after_reset", {63'b0, busy}, 64'd0);
        chk("t4_done_after_reset", {63'b0, done_tick}, 64'd0);
        chk("t4_partial_bytes", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (300) @(negedge clk);
        chk("t4_no_done_after_abort", 64'(done_cnt), 64'd0);
        chk("t4_idle_after_abort", {63'b0, busy}, 64'd0);
        push_msg(13'h0000);
        pulse_start(13'h0000);
        wait_done(3000, t);
        chk("t4_frame_len", 64'(t - acc_cyc), 64'd2400);
        repeat (20) @(negedge clk);
        chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("t4_done_count", 64'(done_cnt), 64'd1);

        // Back-to-back messages with start in the cycle after done_tick
        done_cnt = 0;
        push_msg(13'h1FFF);
        pulse_start(13'h1FFF);
        wait_done(3000, t);
        push_msg(13'h1FFF);
        pulse_start(13'h1FFF);
        wait_done(3000, t);
        chk("t5_frame_len", 64'(t - acc_cyc), 64'd2400);
        repeat (20) @(negedge clk);
        chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("t5_done_count", 64'(done_cnt), 64'd2);

        // First-byte bit timing with baud_tick every 327 clocks
        slow = 1'b1;
        exp_q.push_back(8'h31);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (phase == 326) begin
                ok = 1'b1;
                break;
            end
        end
        chk("slow_phase_found", {63'b0, ok}, 64'd1);
        instruction = 13'b1000000000101;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int b = 0; b < 10; b++) begin
            ok = 1'b1;
            for (int c = 0; c < 5232; c++) begin
                @(negedge clk);
                if (tx !== slow_bits[b]) ok = 1'b0;
            end
            chk($sformatf("slow_bit%0d_held_5232", b), {63'b0, ok}, 64'd1);
        end
        @(negedge clk);
        chk("slow_next_start_bit", {63'b0, tx}, 64'd0);
        chk("slow_queue_empty", 64'(exp_q.size()), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        slow = 1'b0;
        @(negedge clk);
        chk("final_tx_idle", {63'b0, tx}, 64'd1);
        chk("final_busy_idle", {63'b0, busy}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
